// File: rtl/memory_game_ctrl.sv
// Two-level pattern memory game: shows a 16-bit pattern MSB first, then scores player entries.
// Optional build macro REPLAY_ON_MISS_EN replays the whole pattern after a non-fatal miss.
module memory_game_ctrl #(
    parameter int LIVES_INIT = 3,
    parameter int SHOW_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       tick,
    input  logic       btn_valid,
    input  logic       btn_bit,
    output logic       show_valid,
    output logic       show_bit,
    output logic       hit,
    output logic       miss,
    output logic [1:0] lives,
    output logic [7:0] score,
    output logic [4:0] combo,
    output logic       level,
    output logic [3:0] idx,
    output logic [2:0] o_state,
    output logic       game_over,
    output logic       win
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SHOW      = 3'd1,
        INPUT     = 3'd2,
        LVL_DONE  = 3'd3,
        GAME_OVER = 3'd4,
        WIN       = 3'd5
    } state_t;

    localparam logic [15:0] PAT0       = 16'hC3A5;
    localparam logic [15:0] PAT1       = 16'h96AB;
    localparam logic [3:0]  TICK_LAST  = 4'(SHOW_TICKS - 1);
    localparam logic [1:0]  LIVES_LOAD = 2'(LIVES_INIT);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic        level_q, level_d;
    logic [1:0]  lives_q, lives_d;
    logic [7:0]  score_q, score_d;
    logic [4:0]  combo_q, combo_d;
    logic [3:0]  tick_cnt_q, tick_cnt_d;
    logic        hit_q, hit_d;
    logic        miss_q, miss_d;
    logic        show_valid_q, show_valid_d;
    logic        show_bit_q, show_bit_d;
    logic        game_over_q, game_over_d;
    logic        win_q, win_d;

    logic [15:0] cur_pat;
    logic        cur_bit;
    logic [15:0] nxt_pat;
    logic [8:0]  score_sum;
    logic [8:0]  score_inc;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        level_d    = level_q;
        lives_d    = lives_q;
        score_d    = score_q;
        combo_d    = combo_q;
        tick_cnt_d = tick_cnt_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        cur_pat    = level_q ? PAT1 : PAT0;
        cur_bit    = cur_pat[4'd15 - idx_q];
        // A streak of four or more earns a bonus point on the next hit.
        score_inc  = (combo_q >= 5'd4) ? 9'd2 : 9'd1;
        score_sum  = {1'b0, score_q} + score_inc;

        case (state_q)
            IDLE, GAME_OVER, WIN: begin
                if (start) begin
                    state_d    = SHOW;
                    level_d    = 1'b0;
                    idx_d      = 4'd0;
                    lives_d    = LIVES_LOAD;
                    score_d    = 8'd0;
                    combo_d    = 5'd0;
                    tick_cnt_d = 4'd0;
                end
            end
            SHOW: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = 4'd0;
                        idx_d      = idx_q + 4'd1;
                        if (idx_q == 4'd15) begin
                            state_d = INPUT;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            INPUT: begin
                if (btn_valid) begin
                    if (btn_bit == cur_bit) begin
                        hit_d   = 1'b1;
                        combo_d = (combo_q == 5'd31) ? 5'd31 : combo_q + 5'd1;
                        score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
                        idx_d   = idx_q + 4'd1;
                        if (idx_q == 4'd15) begin
                            state_d = LVL_DONE;
                        end
                    end else begin
                        miss_d  = 1'b1;
                        combo_d = 5'd0;
                        if (lives_q <= 2'd1) begin
                            lives_d = 2'd0;
                            state_d = GAME_OVER;
                        end else begin
                            lives_d = lives_q - 2'd1;
`ifdef REPLAY_ON_MISS_EN
                            state_d    = SHOW;
                            idx_d      = 4'd0;
                            tick_cnt_d = 4'd0;
`else
                            state_d    = INPUT;
`endif
                        end
                    end
                end
            end
            LVL_DONE: begin
                if (!level_q) begin
                    state_d    = SHOW;
                    level_d    = 1'b1;
                    idx_d      = 4'd0;
                    tick_cnt_d = 4'd0;
                end else begin
                    state_d = WIN;
                end
            end
            default: state_d = IDLE;
        endcase

        // Display outputs are computed from next-state so they stay registered.
        nxt_pat      = level_d ? PAT1 : PAT0;
        show_valid_d = (state_d == SHOW);
        show_bit_d   = show_valid_d & nxt_pat[4'd15 - idx_d];
        game_over_d  = (state_d == GAME_OVER);
        win_d        = (state_d == WIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= 4'd0;
            level_q      <= 1'b0;
            lives_q      <= 2'd0;
            score_q      <= 8'd0;
            combo_q      <= 5'd0;
            tick_cnt_q   <= 4'd0;
            hit_q        <= 1'b0;
            miss_q       <= 1'b0;
            show_valid_q <= 1'b0;
            show_bit_q   <= 1'b0;
            game_over_q  <= 1'b0;
            win_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            level_q      <= level_d;
            lives_q      <= lives_d;
            score_q      <= score_d;
            combo_q      <= combo_d;
            tick_cnt_q   <= tick_cnt_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
            show_valid_q <= show_valid_d;
            show_bit_q   <= show_bit_d;
            game_over_q  <= game_over_d;
            win_q        <= win_d;
        end
    end

    assign show_valid = show_valid_q;
    assign show_bit   = show_bit_q;
    assign hit        = hit_q;
    assign miss       = miss_q;
    assign lives      = lives_q;
    assign score      = score_q;
    assign combo      = combo_q;
    assign level      = level_q;
    assign idx        = idx_q;
    assign o_state    = state_q;
    assign game_over  = game_over_q;
    assign win        = win_q;

endmodule

// File: doc/memory_game_ctrl.md
MEMORY_GAME_CTRL -- requirements
Module: memory_game_ctrl

Interface
REQ-001 SHALL have parameter LIVES_INIT, default 3, the lives loaded at game start (range 1..3).
REQ-002 SHALL have parameter SHOW_TICKS, default 4, the tick strobes each pattern bit is displayed (range 1..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, one-cycle pulse that begins a new game.
REQ-006 SHALL have port tick, input, 1, one-cycle display timing strobe.
REQ-007 SHALL have port btn_valid, input, 1, one-cycle pulse marking a player entry.
REQ-008 SHALL have port btn_bit, input, 1, the entered bit, qualified by btn_valid.
REQ-009 SHALL have port show_valid, output, 1, high while a pattern bit is being displayed.
REQ-010 SHALL have port show_bit, output, 1, the displayed pattern bit.
REQ-011 SHALL have port hit / miss, output, 1 each, one-cycle pulses for a correct or wrong entry.
REQ-012 SHALL have port lives, output, 2, remaining lives.
REQ-013 SHALL have port score, output, 8, accumulated score.
REQ-014 SHALL have port combo, output, 5, consecutive correct entries.
REQ-015 SHALL have port level, output, 1, current level (0 or 1).
REQ-016 SHALL have port idx, output, 4, current bit position (0 = MSB).
REQ-017 SHALL have port o_state, output, 3, state encoding; game_over and win, output, 1 each, level flags.

Function
REQ-018 SHALL hold fixed patterns PAT0 = 16'hC3A5 (level 0) and PAT1 = 16'h96AB (level 1), presented and checked MSB first, current bit = PAT[15-idx].
REQ-019 SHALL implement states IDLE=0, SHOW=1, INPUT=2, LVL_DONE=3, GAME_OVER=4, WIN=5.
REQ-020 IDLE/GAME_OVER/WIN: start -> SHOW next cycle with level=0, idx=0, lives=LIVES_INIT, score=0, combo=0, tick-counter=0.
REQ-021 SHOW: show_valid=1, show_bit=current bit; each tick increments the tick-counter; on the SHOW_TICKS-th tick, counter clears and idx increments; at idx=15 this goes to INPUT with idx=0.
REQ-022 INPUT: btn_valid with btn_bit equal to the current bit -> hit pulse next cycle, combo+1 (saturate 31), score +1, plus 1 bonus when prior combo >=4, saturating at 255, idx+1.
REQ-023 INPUT: btn_valid with a wrong bit -> miss pulse next cycle, combo=0, lives-1, idx unchanged (see REQ-031 for macro).
REQ-024 A miss with lives=1 SHALL go to GAME_OVER with lives=0; game_over=1 while in GAME_OVER.
REQ-025 A hit at idx=15 SHALL go to LVL_DONE for exactly one cycle; then level=0 -> SHOW with level=1, idx=0; level=1 -> WIN; win=1 while in WIN.
REQ-026 Ignored events: btn_valid outside INPUT; tick outside SHOW; start in SHOW, INPUT or LVL_DONE.
REQ-027 show_valid=0 and show_bit=0 in every state except SHOW; hit and miss never assert together.
REQ-028 All outputs SHALL be registered; one cycle latency from any input event to the affected outputs.

Reset
REQ-029 reset SHALL override all inputs: state=IDLE, idx=0, level=0, lives=0, score=0, combo=0, tick-counter=0, all pulses and flags 0.
REQ-030 reset asserted mid-SHOW or mid-INPUT SHALL abandon the game, with no hit or miss pulse emitted.

Configuration
REQ-031 Macro REPLAY_ON_MISS_EN: when defined, a non-fatal miss SHALL go to SHOW with idx=0 and tick-counter=0, replaying the whole pattern. When undefined, the controller SHALL stay in INPUT at the same idx.

Verification
REQ-032 reset, start, SHOW_TICKS=4 -> show_bit follows C3A5 MSB first, 4 ticks per bit; INPUT after 64 ticks.
REQ-033 Enter 16 correct level-0 bits -> score=16+12=28, combo=16, LVL_DONE for 1 cycle, then SHOW with level=1.
REQ-034 In INPUT, idx=5, enter a wrong bit -> miss pulse, lives 3->2, combo=0, idx=5 (no macro) or SHOW with idx=0 (macro).
REQ-035 Three consecutive misses -> lives=0, GAME_OVER, game_over=1; then start -> SHOW, lives=3, score=0.
REQ-036 Complete both levels without a miss -> WIN, win=1; btn_valid and tick in WIN produce no change.
REQ-037 Assert reset during INPUT at idx=9 together with btn_valid -> IDLE, all outputs 0, no hit or miss.
